lsu: RTL and testbench

Load/store unit forming the MEM stage of the rv32i pipeline, between the EX/MEM register and the MEM/WB register. It passes non-memory instructions through unchanged. For memory instructions it runs a request/acknowledge transaction on the data-memory bus, stalling upstream until the access completes. It aligns and extends load data into the writeback result, and flags misaligned accesses and bus timeouts.

---
 rtl/rv32i_pkg.sv | 28 ++
 rtl/lsu_align.sv | 92 +++++++++
 rtl/lsu.sv | 185 ++++++++++++++++++
 tb/tb_lsu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_pkg
// Description : Shared rv32i definitions: memory mnemonic codes and the
//               load/store unit state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_pkg;

    // Decoded mnemonic codes seen by the MEM stage (0 is a bubble)
    localparam logic [5:0] NOP = 6'd0;
    localparam logic [5:0] LB  = 6'd1;
    localparam logic [5:0] LH  = 6'd2;
    localparam logic [5:0] LW  = 6'd3;
    localparam logic [5:0] LBU = 6'd4;
    localparam logic [5:0] LHU = 6'd5;
    localparam logic [5:0] SB  = 6'd6;
    localparam logic [5:0] SH  = 6'd7;
    localparam logic [5:0] SW  = 6'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } lsu_state_t;

endpackage : rv32i_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational data formatting for the load/store unit:
//               store strobe/lane replication, misalign detection and load
//               lane selection with sign/zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [5:0]  st_mnemonic,
    input  logic [1:0]  st_offset,
    input  logic [31:0] st_data,
    output logic        is_mem,
    output logic        is_store,
    output logic        misalign,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [5:0]  ld_mnemonic,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] rdata,
    output logic [31:0] ld_result
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Classify the incoming op and build the bus strobes / replicated data
    always_comb begin
        is_mem   = 1'b0;
        is_store = 1'b0;
        misalign = 1'b0;
        st_wstrb = 4'b0000;
        st_wdata = 32'h0;
        case (st_mnemonic)
            LB, LBU: begin
                is_mem = 1'b1;
            end
            LH, LHU: begin
                is_mem   = 1'b1;
                misalign = st_offset[0];
            end
            LW: begin
                is_mem   = 1'b1;
                misalign = |st_offset;
            end
            SB: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                st_wstrb = 4'b0001 << st_offset;
                st_wdata = {4{st_data[7:0]}};
            end
            SH: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                misalign = st_offset[0];
                st_wstrb = 4'b0011 << {st_offset[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            SW: begin
                is_mem   = 1'b1;
                is_store = 1'b1;
                misalign = |st_offset;
                st_wstrb = 4'b1111;
                st_wdata = st_data;
            end
            default: ;
        endcase
    end

    // Pick the addressed byte/half of the read word and extend it
    always_comb begin
        case (ld_offset)
            2'd0:    ld_byte = rdata[7:0];
            2'd1:    ld_byte = rdata[15:8];
            2'd2:    ld_byte = rdata[23:16];
            default: ld_byte = rdata[31:24];
        endcase
        ld_half = ld_offset[1] ? rdata[31:16] : rdata[15:0];
        case (ld_mnemonic)
            LB:      ld_result = {{24{ld_byte[7]}}, ld_byte};
            LBU:     ld_result = {24'h0, ld_byte};
            LH:      ld_result = {{16{ld_half[15]}}, ld_half};
            LHU:     ld_result = {16'h0, ld_half};
            LW:      ld_result = rdata;
            default: ld_result = 32'h0;
        endcase
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module      : lsu
// Description : rv32i MEM-stage load/store unit. Passes non-memory ops
//               through, runs a req/ack data-bus transaction for memory
//               ops while stalling upstream, and flags misaligned accesses
//               and bus timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu
    import rv32i_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  i_mnemonic,
    input  logic [4:0]  i_rd_addr,
    input  logic [31:0] i_ALUout,
    input  logic [31:0] i_rs2_data,
    input  logic        i_rd_wr,
    output logic        o_stall,
    output logic        o_dm_req,
    output logic        o_dm_we,
    output logic [31:0] o_dm_addr,
    output logic [3:0]  o_dm_wstrb,
    output logic [31:0] o_dm_wdata,
    input  logic        i_dm_ack,
    input  logic [31:0] i_dm_rdata,
    output logic [5:0]  o_mnemonic,
    output logic [4:0]  o_rd_addr,
    output logic [31:0] o_ALUout,
    output logic        o_rd_wr,
    output logic        o_misalign,
    output logic        o_bus_err
);

    localparam int             CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0]  LAST_CNT = CW'(MAX_WAIT - 1);

    lsu_state_t  state;
    logic [CW-1:0] wait_cnt;
    logic [31:0] req_addr;
    logic [3:0]  req_wstrb;
    logic [31:0] req_wdata;
    logic        req_we;
    logic [5:0]  req_mnemonic;
    logic [4:0]  req_rd_addr;
    logic        req_rd_wr;
    logic [31:0] load_result;
    logic        timeout;

    logic        is_mem;
    logic        is_store;
    logic        misalign;
    logic [3:0]  st_wstrb;
    logic [31:0] st_wdata;
    logic [31:0] ld_result;
    logic        accept;

    lsu_align u_align (
        .st_mnemonic (i_mnemonic),
        .st_offset   (i_ALUout[1:0]),
        .st_data     (i_rs2_data),
        .is_mem      (is_mem),
        .is_store    (is_store),
        .misalign    (misalign),
        .st_wstrb    (st_wstrb),
        .st_wdata    (st_wdata),
        .ld_mnemonic (req_mnemonic),
        .ld_offset   (req_addr[1:0]),
        .rdata       (i_dm_rdata),
        .ld_result   (ld_result)
    );

    // Misaligned ops are retired immediately with a flag, never sent to the bus
    assign accept = (state == S_IDLE) && is_mem && !misalign;

    // Transaction FSM, wait counter and request/result capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            wait_cnt     <= '0;
            req_addr     <= 32'h0;
            req_wstrb    <= 4'h0;
            req_wdata    <= 32'h0;
            req_we       <= 1'b0;
            req_mnemonic <= NOP;
            req_rd_addr  <= 5'h0;
            req_rd_wr    <= 1'b0;
            load_result  <= 32'h0;
            timeout      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        req_addr     <= i_ALUout;
                        req_wstrb    <= st_wstrb;
                        req_wdata    <= st_wdata;
                        req_we       <= is_store;
                        req_mnemonic <= i_mnemonic;
                        req_rd_addr  <= i_rd_addr;
                        req_rd_wr    <= i_rd_wr;
                        wait_cnt     <= '0;
                        timeout      <= 1'b0;
                        state        <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ack wins over timeout when both land in the same cycle
                    if (i_dm_ack) begin
                        load_result <= ld_result;
                        timeout     <= 1'b0;
                        state       <= S_RESP;
                    end else if (wait_cnt == LAST_CNT) begin
                        timeout <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output steering; everything is forced low while reset is asserted
    always_comb begin
        o_stall    = 1'b0;
        o_dm_req   = 1'b0;
        o_dm_we    = 1'b0;
        o_dm_addr  = 32'h0;
        o_dm_wstrb = 4'h0;
        o_dm_wdata = 32'h0;
        o_mnemonic = NOP;
        o_rd_addr  = 5'h0;
        o_ALUout   = 32'h0;
        o_rd_wr    = 1'b0;
        o_misalign = 1'b0;
        o_bus_err  = 1'b0;
        if (rst) begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        o_stall = 1'b1;
                    end else begin
                        o_mnemonic = i_mnemonic;
                        o_rd_addr  = i_rd_addr;
                        o_ALUout   = i_ALUout;
                        o_rd_wr    = i_rd_wr && !misalign;
                        o_misalign = misalign;
                    end
                end
                S_WAIT: begin
                    o_stall    = 1'b1;
                    o_dm_req   = 1'b1;
                    o_dm_we    = req_we;
                    o_dm_addr  = {req_addr[31:2], 2'b00};
                    o_dm_wstrb = req_wstrb;
                    o_dm_wdata = req_wdata;
                end
                S_RESP: begin
                    o_mnemonic = req_mnemonic;
                    o_rd_addr  = req_rd_addr;
                    if (timeout) begin
                        o_bus_err = 1'b1;
                    end else if (req_we) begin
                        o_ALUout = req_addr;
                    end else begin
                        o_ALUout = load_result;
                        o_rd_wr  = req_rd_wr;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule : lsu
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu
// Description : Directed self-checking bench for the load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu;
    import rv32i_pkg::*;

    localparam int         MAX_WAIT = 4;
    localparam logic [5:0] ADD      = 6'd9;

    logic        clk;
    logic        rst;
    logic [5:0]  i_mnemonic;
    logic [4:0]  i_rd_addr;
    logic [31:0] i_ALUout;
    logic [31:0] i_rs2_data;
    logic        i_rd_wr;
    logic        o_stall;
    logic        o_dm_req;
    logic        o_dm_we;
    logic [31:0] o_dm_addr;
    logic [3:0]  o_dm_wstrb;
    logic [31:0] o_dm_wdata;
    logic        i_dm_ack;
    logic [31:0] i_dm_rdata;
    logic [5:0]  o_mnemonic;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_ALUout;
    logic        o_rd_wr;
    logic        o_misalign;
    logic        o_bus_err;

    int n_checks = 0;
    int n_fail   = 0;

    lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_mnemonic (i_mnemonic),
        .i_rd_addr  (i_rd_addr),
        .i_ALUout   (i_ALUout),
        .i_rs2_data (i_rs2_data),
        .i_rd_wr    (i_rd_wr),
        .o_stall    (o_stall),
        .o_dm_req   (o_dm_req),
        .o_dm_we    (o_dm_we),
        .o_dm_addr  (o_dm_addr),
        .o_dm_wstrb (o_dm_wstrb),
        .o_dm_wdata (o_dm_wdata),
        .i_dm_ack   (i_dm_ack),
        .i_dm_rdata (i_dm_rdata),
        .o_mnemonic (o_mnemonic),
        .o_rd_addr  (o_rd_addr),
        .o_ALUout   (o_ALUout),
        .o_rd_wr    (o_rd_wr),
        .o_misalign (o_misalign),
        .o_bus_err  (o_bus_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an instruction on a falling edge and let outputs settle
    task automatic issue(input logic [5:0] mn, input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rdwr);
        @(negedge clk);
        i_mnemonic = mn;
        i_ALUout   = addr;
        i_rs2_data = data;
        i_rd_addr  = rd;
        i_rd_wr    = rdwr;
        #1;
    endtask

    // Walk k WAIT cycles checking bus fields; optionally ack on the last one.
    // Returns settled inside the RESP cycle.
    task automatic wait_bus(input int k, input logic give_ack, input logic [31:0] rdata,
                            input logic [31:0] exp_addr, input logic exp_we,
                            input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata);
        for (int i = 1; i <= k; i++) begin
            @(negedge clk);
            #1;
            chk("wait_req", o_dm_req, 1);
            chk("wait_stall", o_stall, 1);
            chk("wait_mnem_bubble", o_mnemonic, 0);
            chk("wait_addr", o_dm_addr, exp_addr);
            chk("wait_we", o_dm_we, exp_we);
            chk("wait_wstrb", o_dm_wstrb, exp_wstrb);
            chk("wait_wdata", o_dm_wdata, exp_wdata);
            if (i == k && give_ack) begin
                i_dm_ack   = 1'b1;
                i_dm_rdata = rdata;
            end
        end
        @(negedge clk);
        i_dm_ack   = 1'b0;
        i_dm_rdata = 32'h0;
        #1;
        chk("resp_req", o_dm_req, 0);
        chk("resp_stall", o_stall, 0);
    endtask

    // Directed scenario sequence
    initial begin
        rst        = 1'b0;
        i_mnemonic = NOP;
        i_rd_addr  = 5'd0;
        i_ALUout   = 32'h0;
        i_rs2_data = 32'h0;
        i_rd_wr    = 1'b0;
        i_dm_ack   = 1'b0;
        i_dm_rdata = 32'h0;

        // Reset holds every output low even with an instruction present
        issue(ADD, 32'h1234, 32'h0, 5'd5, 1'b1);
        chk("rst_alu", o_ALUout, 0);
        chk("rst_rdwr", o_rd_wr, 0);
        chk("rst_mnem", o_mnemonic, 0);
        chk("rst_stall", o_stall, 0);
        chk("rst_req", o_dm_req, 0);

        // ADD passes straight through
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("add_alu", o_ALUout, 32'h1234);
        chk("add_rd", o_rd_addr, 5);
        chk("add_rdwr", o_rd_wr, 1);
        chk("add_mnem", o_mnemonic, ADD);
        chk("add_stall", o_stall, 0);
        chk("add_req", o_dm_req, 0);

        // LB at 0x103: lane 3 = 0x80, sign-extended
        issue(LB, 32'h103, 32'h0, 5'd3, 1'b1);
        chk("lb_accept_stall", o_stall, 1);
        chk("lb_accept_req", o_dm_req, 0);
        chk("lb_accept_bubble_rdwr", o_rd_wr, 0);
        wait_bus(1, 1'b1, 32'h80AABBCC, 32'h100, 1'b0, 4'h0, 32'h0);
        chk("lb_result", o_ALUout, 32'hFFFFFF80);
        chk("lb_rdwr", o_rd_wr, 1);
        chk("lb_rd", o_rd_addr, 3);
        chk("lb_mnem", o_mnemonic, LB);

        // LBU in the same setup is zero-extended
        issue(LBU, 32'h103, 32'h0, 5'd4, 1'b1);
        chk("lbu_accept_stall", o_stall, 1);
        wait_bus(1, 1'b1, 32'h80AABBCC, 32'h100, 1'b0, 4'h0, 32'h0);
        chk("lbu_result", o_ALUout, 32'h00000080);
        chk("lbu_rdwr", o_rd_wr, 1);

        // SH at 0x202: upper half strobes, half replicated
        issue(SH, 32'h202, 32'hDEADBEEF, 5'd0, 1'b0);
        chk("sh_accept_stall", o_stall, 1);
        wait_bus(1, 1'b1, 32'h0, 32'h200, 1'b1, 4'b1100, 32'hBEEFBEEF);
        chk("sh_resp_alu", o_ALUout, 32'h202);
        chk("sh_resp_rdwr", o_rd_wr, 0);

        // SB at 0x801: byte lane 1
        issue(SB, 32'h801, 32'h12345678, 5'd0, 1'b0);
        wait_bus(1, 1'b1, 32'h0, 32'h800, 1'b1, 4'b0010, 32'h78787878);
        chk("sb_resp_alu", o_ALUout, 32'h801);

        // Misaligned LW retires at once with the flag and no bus activity
        issue(LW, 32'h301, 32'h0, 5'd6, 1'b1);
        chk("mis_flag", o_misalign, 1);
        chk("mis_rdwr", o_rd_wr, 0);
        chk("mis_stall", o_stall, 0);
        chk("mis_req", o_dm_req, 0);
        chk("mis_alu", o_ALUout, 32'h301);
        issue(NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        chk("mis_next_req", o_dm_req, 0);
        chk("mis_next_flag", o_misalign, 0);

        // LH at 0x602: upper half 0x8001 sign-extended, ack after 2 cycles
        issue(LH, 32'h602, 32'h0, 5'd8, 1'b1);
        wait_bus(2, 1'b1, 32'h80015555, 32'h600, 1'b0, 4'h0, 32'h0);
        chk("lh_result", o_ALUout, 32'hFFFF8001);

        // LHU at 0x600: lower half zero-extended
        issue(LHU, 32'h600, 32'h0, 5'd9, 1'b1);
        wait_bus(1, 1'b1, 32'h1234F00D, 32'h600, 1'b0, 4'h0, 32'h0);
        chk("lhu_result", o_ALUout, 32'h0000F00D);

        // LW with no ack times out after MAX_WAIT request cycles
        issue(LW, 32'h400, 32'h0, 5'd10, 1'b1);
        chk("to_accept_stall", o_stall, 1);
        wait_bus(MAX_WAIT, 1'b0, 32'h0, 32'h400, 1'b0, 4'h0, 32'h0);
        chk("to_bus_err", o_bus_err, 1);
        chk("to_rdwr", o_rd_wr, 0);
        chk("to_alu", o_ALUout, 0);
        // Late ack while idle has no effect
        issue(NOP, 32'h0, 32'h0, 5'd0, 1'b0);
        i_dm_ack = 1'b1;
        #1;
        chk("late_ack_req", o_dm_req, 0);
        chk("late_ack_stall", o_stall, 0);
        chk("late_ack_err", o_bus_err, 0);
        @(negedge clk);
        i_dm_ack = 1'b0;
        #1;
        chk("late_ack_next_req", o_dm_req, 0);
        chk("late_ack_next_rdwr", o_rd_wr, 0);

        // Ack on the final allowed wait cycle is a success
        issue(LW, 32'h500, 32'h0, 5'd11, 1'b1);
        wait_bus(MAX_WAIT, 1'b1, 32'h11223344, 32'h500, 1'b0, 4'h0, 32'h0);
        chk("edge_result", o_ALUout, 32'h11223344);
        chk("edge_err", o_bus_err, 0);
        chk("edge_rdwr", o_rd_wr, 1);

        // Reset mid-WAIT abandons the transaction immediately
        issue(LW, 32'h700, 32'h0, 5'd12, 1'b1);
        @(negedge clk);
        #1;
        chk("rstw_req_before", o_dm_req, 1);
        rst = 1'b0;
        #1;
        chk("rstw_req", o_dm_req, 0);
        chk("rstw_stall", o_stall, 0);
        chk("rstw_alu", o_ALUout, 0);
        issue(ADD, 32'hABCD, 32'h0, 5'd7, 1'b1);
        rst      = 1'b1;
        i_dm_ack = 1'b1;
        #1;
        chk("post_rst_add_alu", o_ALUout, 32'hABCD);
        chk("post_rst_add_rdwr", o_rd_wr, 1);
        chk("post_rst_add_stall", o_stall, 0);
        chk("post_rst_add_req", o_dm_req, 0);
        @(negedge clk);
        i_dm_ack = 1'b0;
        #1;
        chk("post_rst_next_req", o_dm_req, 0);
        chk("post_rst_next_stall", o_stall, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_lsu
`default_nettype wire
